// File: rtl/idct_pkg.sv
// idct_pkg: shared definitions for the IDCT block sequencer.
//   idct_seq_state_t    - sequencer FSM states (IDLE, LOAD, WAIT, DRAIN)
//   IDCT_ROWS_PER_BLOCK - rows in one 8x8 block
//   IDCT_ROW_CNT_W      - width of the per-block row counters
package idct_pkg;

  localparam int IDCT_ROWS_PER_BLOCK = 8;
  localparam int IDCT_ROW_CNT_W      = 3;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_LOAD  = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_DRAIN = 2'd3
  } idct_seq_state_t;

endpackage

// File: rtl/idct_seq_watchdog.sv
// idct_seq_watchdog: cycle counter with a sticky error flag.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   run_i        - counter advances while high, held at 0 while low
//   clear_i      - restarts the count (progress seen)
//   expire_o     - high in the cycle the count reaches TIMEOUT_CYCLES
//   err_o        - sticky error, cleared only by rst_i
module idct_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o,
  output logic err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // cnt_q counts completed idle cycles; the TIMEOUT_CYCLES-th one expires.
  assign expire_o = run_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err_o    = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | expire_o;
    if (clear_i || !run_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/idct_block_sequencer.sv
// idct_block_sequencer: block-level controller in front of idct_2d.
// Admits an 8-row coefficient block only when downstream grants room for a
// whole block, streams it into the datapath, then forwards the 8 returned
// pixel rows with a last-row marker. One block in flight at a time.
// Handshake: an upstream row transfers on a cycle where row_valid_in and
// row_ready_out are both high; row_ready_out is high only in LOAD and does
// not depend on row_valid_in. Datapath and downstream sides are pulse-only.
// Optional feature: define IDCT_SEQ_TIMEOUT_EN to add a WAIT/DRAIN watchdog
// (idct_seq_watchdog); otherwise timeout_err_out is tied low.
// Ports:
//   clk_in, rst_in                  - clock, synchronous active-high reset
//   row_in/row_valid_in/row_ready_out - upstream coefficient rows
//   blk_ready_in                    - downstream can absorb a whole block
//   dp_row_out/dp_valid_out         - rows into the datapath
//   dp_pix_in/dp_valid_in/dp_final_in - pixel rows from the datapath
//   pix_row_out/pix_valid_out/pix_last_out - pixel rows downstream
//   busy_out                        - not IDLE
//   block_count_out                 - completed blocks (wrapping)
//   timeout_err_out                 - sticky watchdog error
module idct_block_sequencer
  import idct_pkg::*;
#(
  parameter int WIDTH          = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [WIDTH*8-1:0]     row_in,
  input  logic                   row_valid_in,
  output logic                   row_ready_out,
  input  logic                   blk_ready_in,
  output logic [WIDTH*8-1:0]     dp_row_out,
  output logic                   dp_valid_out,
  input  logic [(WIDTH-4)*8-1:0] dp_pix_in,
  input  logic                   dp_valid_in,
  input  logic                   dp_final_in,
  output logic [(WIDTH-4)*8-1:0] pix_row_out,
  output logic                   pix_valid_out,
  output logic                   pix_last_out,
  output logic                   busy_out,
  output logic [15:0]            block_count_out,
  output logic                   timeout_err_out
);

  localparam int PIX_W = (WIDTH - 4) * 8;
  localparam logic [IDCT_ROW_CNT_W-1:0] LAST_ROW =
    IDCT_ROW_CNT_W'(IDCT_ROWS_PER_BLOCK - 1);

  idct_seq_state_t           state_q, state_d;
  logic [IDCT_ROW_CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [IDCT_ROW_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [WIDTH*8-1:0]        dp_row_q, dp_row_d;
  logic                      dp_valid_q, dp_valid_d;
  logic [PIX_W-1:0]          pix_row_q, pix_row_d;
  logic                      pix_valid_q, pix_valid_d;
  logic                      pix_last_q, pix_last_d;
  logic [15:0]               block_count_q, block_count_d;

  logic wd_run, wd_clear, wd_expire, wd_err;

  // Block end is defined by out_cnt, so the datapath's final flag is unused.
  logic final_unused;
  assign final_unused = dp_final_in;

  assign wd_run = (state_q == SEQ_WAIT) || (state_q == SEQ_DRAIN);

`ifdef IDCT_SEQ_TIMEOUT_EN
  idct_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .run_i   (wd_run),
    .clear_i (wd_clear),
    .expire_o(wd_expire),
    .err_o   (wd_err)
  );
`else
  logic wd_unused;
  assign wd_unused = wd_run ^ wd_clear ^ (TIMEOUT_CYCLES > 0);
  assign wd_expire = 1'b0;
  assign wd_err    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    dp_row_d      = dp_row_q;
    dp_valid_d    = 1'b0;
    pix_row_d     = pix_row_q;
    pix_valid_d   = 1'b0;
    pix_last_d    = 1'b0;
    block_count_d = block_count_q;
    wd_clear      = 1'b0;
    row_ready_out = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        // The grant is sampled only here; a later drop does not stop the block.
        if (blk_ready_in) begin
          state_d   = SEQ_LOAD;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      SEQ_LOAD: begin
        row_ready_out = 1'b1;
        if (row_valid_in) begin
          dp_row_d   = row_in;
          dp_valid_d = 1'b1;
          in_cnt_d   = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST_ROW) begin
            state_d  = SEQ_WAIT;
            wd_clear = 1'b1;
          end
        end
      end
      SEQ_WAIT, SEQ_DRAIN: begin
        if (dp_valid_in) begin
          // The first returned row is already a DRAIN row.
          state_d     = SEQ_DRAIN;
          wd_clear    = 1'b1;
          pix_row_d   = dp_pix_in;
          pix_valid_d = 1'b1;
          out_cnt_d   = out_cnt_q + 1'b1;
          if (out_cnt_q == LAST_ROW) begin
            pix_last_d    = 1'b1;
            state_d       = SEQ_IDLE;
            block_count_d = block_count_q + 16'd1;
          end
        end else if (wd_expire) begin
          state_d   = SEQ_IDLE;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= SEQ_IDLE;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      dp_row_q      <= '0;
      dp_valid_q    <= 1'b0;
      pix_row_q     <= '0;
      pix_valid_q   <= 1'b0;
      pix_last_q    <= 1'b0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      dp_row_q      <= dp_row_d;
      dp_valid_q    <= dp_valid_d;
      pix_row_q     <= pix_row_d;
      pix_valid_q   <= pix_valid_d;
      pix_last_q    <= pix_last_d;
      block_count_q <= block_count_d;
    end
  end

  assign dp_row_out      = dp_row_q;
  assign dp_valid_out    = dp_valid_q;
  assign pix_row_out     = pix_row_q;
  assign pix_valid_out   = pix_valid_q;
  assign pix_last_out    = pix_last_q;
  assign busy_out        = (state_q != SEQ_IDLE);
  assign block_count_out = block_count_q;
  assign timeout_err_out = wd_err;

endmodule

// File: tb/tb_idct_block_sequencer.sv
// tb_idct_block_sequencer: directed bench for idct_block_sequencer.
// Stimulus tasks push expected datapath rows and pixel rows into queues; a
// monitor pops and compares whenever dp_valid_out / pix_valid_out is seen.
module tb_idct_block_sequencer;

  localparam int WIDTH     = 12;
  localparam int ROW_W     = WIDTH * 8;
  localparam int PIX_ROW_W = (WIDTH - 4) * 8;

  logic                 clk_in;
  logic                 rst_in;
  logic [ROW_W-1:0]     row_in;
  logic                 row_valid_in;
  logic                 row_ready_out;
  logic                 blk_ready_in;
  logic [ROW_W-1:0]     dp_row_out;
  logic                 dp_valid_out;
  logic [PIX_ROW_W-1:0] dp_pix_in;
  logic                 dp_valid_in;
  logic                 dp_final_in;
  logic [PIX_ROW_W-1:0] pix_row_out;
  logic                 pix_valid_out;
  logic                 pix_last_out;
  logic                 busy_out;
  logic [15:0]          block_count_out;
  logic                 timeout_err_out;

  idct_block_sequencer #(
    .WIDTH(WIDTH),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .row_in         (row_in),
    .row_valid_in   (row_valid_in),
    .row_ready_out  (row_ready_out),
    .blk_ready_in   (blk_ready_in),
    .dp_row_out     (dp_row_out),
    .dp_valid_out   (dp_valid_out),
    .dp_pix_in      (dp_pix_in),
    .dp_valid_in    (dp_valid_in),
    .dp_final_in    (dp_final_in),
    .pix_row_out    (pix_row_out),
    .pix_valid_out  (pix_valid_out),
    .pix_last_out   (pix_last_out),
    .busy_out       (busy_out),
    .block_count_out(block_count_out),
    .timeout_err_out(timeout_err_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  logic [ROW_W-1:0]   dp_exp_q[$];
  logic [PIX_ROW_W:0] pix_exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [ROW_W-1:0]   mon_dp_e;
  logic [PIX_ROW_W:0] mon_pix_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (dp_valid_out === 1'b1) begin
      if (dp_exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL dp_unexpected: got dp_valid_out row %0h expected no beat", dp_row_out);
      end else begin
        mon_dp_e = dp_exp_q.pop_front();
        check("dp_row", 128'(dp_row_out), 128'(mon_dp_e));
      end
    end
    if (pix_valid_out === 1'b1) begin
      if (pix_exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL pix_unexpected: got pix row %0h last %0b expected no beat", pix_row_out, pix_last_out);
      end else begin
        mon_pix_e = pix_exp_q.pop_front();
        check("pix_last_row", 128'({pix_last_out, pix_row_out}), 128'(mon_pix_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] coef_row(input int k);
    logic [WIDTH-1:0] e;
    e = WIDTH'(k);
    return {8{e}};
  endfunction

  function automatic logic [PIX_ROW_W-1:0] pix_row(input int k);
    logic [7:0] e;
    e = 8'(8'h10 + k);
    return {8{e}};
  endfunction

  task automatic push_row(input logic [ROW_W-1:0] d);
    int   n;
    logic took;
    n = 0;
    took = 1'b0;
    row_in = d;
    row_valid_in = 1'b1;
    while (!took && n < 50) begin
      took = row_ready_out;
      tick();
      n++;
    end
    if (took) dp_exp_q.push_back(d);
    else begin
      total_cnt++;
      $display("FAIL row_accept_timeout: got no transfer of row %0h expected one within 50 cycles", d);
    end
    row_valid_in = 1'b0;
  endtask

  task automatic push_pix(input logic [PIX_ROW_W-1:0] p, input logic last);
    dp_pix_in   = p;
    dp_valid_in = 1'b1;
    dp_final_in = last;
    pix_exp_q.push_back({last, p});
    tick();
    dp_valid_in = 1'b0;
    dp_final_in = 1'b0;
  endtask

  task automatic stray_pix();
    dp_pix_in   = pix_row(200);
    dp_valid_in = 1'b1;
    dp_final_in = 1'b1;
    tick();
    dp_valid_in = 1'b0;
    dp_final_in = 1'b0;
  endtask

  task automatic load_block(input int base, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (gaps && k > 0) begin
        row_valid_in = 1'b0;
        tick();
      end
      push_row(coef_row(base + k));
    end
  endtask

  task automatic drain_block(input int base, input bit gaps);
    for (int j = 0; j < 8; j++) begin
      push_pix(pix_row(base + j), j == 7);
      if (gaps) tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dp_valid"}, 128'(dp_valid_out), 128'(0));
    check({tag, "_dp_row"}, 128'(dp_row_out), 128'(0));
    check({tag, "_pix_valid"}, 128'(pix_valid_out), 128'(0));
    check({tag, "_pix_last"}, 128'(pix_last_out), 128'(0));
    check({tag, "_pix_row"}, 128'(pix_row_out), 128'(0));
    check({tag, "_row_ready"}, 128'(row_ready_out), 128'(0));
    check({tag, "_busy"}, 128'(busy_out), 128'(0));
    check({tag, "_count"}, 128'(block_count_out), 128'(0));
    check({tag, "_timeout"}, 128'(timeout_err_out), 128'(0));
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end of test expected finish before 1ms");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    rst_in       = 1'b1;
    row_in       = '0;
    row_valid_in = 1'b0;
    blk_ready_in = 1'b0;
    dp_pix_in    = '0;
    dp_valid_in  = 1'b0;
    dp_final_in  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_in = 1'b0;

    // No grant: upstream valid is never accepted.
    bad = 0;
    row_in = coef_row(99);
    row_valid_in = 1'b1;
    repeat (20) begin
      tick();
      if (row_ready_out !== 1'b0 || busy_out !== 1'b0) bad++;
    end
    row_valid_in = 1'b0;
    check("no_grant_violations", 128'(bad), 128'(0));

    // Stray datapath output while IDLE.
    repeat (3) stray_pix();
    tick();
    check("stray_idle_count", 128'(block_count_out), 128'(0));
    check("stray_idle_busy", 128'(busy_out), 128'(0));

    // Basic block, back-to-back rows; grant dropped mid-block.
    blk_ready_in = 1'b1;
    tick();
    check("load_ready", 128'(row_ready_out), 128'(1));
    check("load_busy", 128'(busy_out), 128'(1));
    load_block(0, 1'b0);
    check("ready_after_8", 128'(row_ready_out), 128'(0));
    blk_ready_in = 1'b0;
    tick();
    tick();
    check("wait_busy", 128'(busy_out), 128'(1));
    check("wait_count", 128'(block_count_out), 128'(0));
    drain_block(0, 1'b0);
    check("basic_count", 128'(block_count_out), 128'(1));
    check("basic_idle", 128'(busy_out), 128'(0));
    tick();
    check("idle_no_grant_ready", 128'(row_ready_out), 128'(0));

    // Upstream gaps; extra rows offered after the 8th must be refused.
    blk_ready_in = 1'b1;
    load_block(16, 1'b1);
    check("gap_ready_after_8", 128'(row_ready_out), 128'(0));
    blk_ready_in = 1'b0;
    row_in = coef_row(50);
    row_valid_in = 1'b1;
    repeat (3) tick();
    row_valid_in = 1'b0;
    drain_block(32, 1'b1);
    check("gap_count", 128'(block_count_out), 128'(2));
    check("gap_idle", 128'(busy_out), 128'(0));

    // Reset after 5 rows, late datapath output ignored, then a clean block.
    blk_ready_in = 1'b1;
    for (int k = 0; k < 5; k++) push_row(coef_row(64 + k));
    rst_in = 1'b1;
    blk_ready_in = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_in = 1'b0;
    repeat (2) stray_pix();
    tick();
    check("post_rst_stray_count", 128'(block_count_out), 128'(0));
    blk_ready_in = 1'b1;
    load_block(80, 1'b0);
    blk_ready_in = 1'b0;
    drain_block(48, 1'b0);
    check("post_rst_count", 128'(block_count_out), 128'(1));

`ifdef IDCT_SEQ_TIMEOUT_EN
    // Watchdog: no datapath output after the 8th row.
    blk_ready_in = 1'b1;
    load_block(100, 1'b0);
    blk_ready_in = 1'b0;
    repeat (15) tick();
    check("wd_before", 128'(timeout_err_out), 128'(0));
    check("wd_before_busy", 128'(busy_out), 128'(1));
    tick();
    check("wd_err", 128'(timeout_err_out), 128'(1));
    check("wd_idle", 128'(busy_out), 128'(0));
    check("wd_count", 128'(block_count_out), 128'(1));
    repeat (3) tick();
    check("wd_sticky", 128'(timeout_err_out), 128'(1));
`else
    check("no_wd_err", 128'(timeout_err_out), 128'(0));
`endif

    repeat (2) tick();
    check("dp_queue_empty", 128'(dp_exp_q.size()), 128'(0));
    check("pix_queue_empty", 128'(pix_exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
